// File: rtl/top_if.sv
// Word-wide access channel into the global buffer.
// The master drives address/write, the slave returns registered read data.
interface top_if #(
    parameter int AW = 16
);
    logic [AW-1:0] addr;
    logic          we;
    logic [31:0]   wdata;
    logic [31:0]   rdata;

    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/top.sv
// Single-pass int8 convolution engine with a byte-addressed global buffer.
// Optional macro OPSUM_RELU_EN clamps negative opsums to zero before write-back.
module top_glb #(
    parameter int BYTES = 65536,
    parameter int AW    = 16
) (
    input logic  clk,
    top_if.slave bus
);
    logic [7:0]    mem [0:BYTES-1];
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-1:0] a3;
    logic [31:0]   rdata_q;

    // Byte lanes wrap around the top of the buffer.
    assign a1 = bus.addr + AW'(1);
    assign a2 = bus.addr + AW'(2);
    assign a3 = bus.addr + AW'(3);

    always_ff @(posedge clk) begin
        if (bus.we) begin
            mem[bus.addr] <= bus.wdata[7:0];
            mem[a1]       <= bus.wdata[15:8];
            mem[a2]       <= bus.wdata[23:16];
            mem[a3]       <= bus.wdata[31:24];
        end
        rdata_q <= {mem[a3], mem[a2], mem[a1], mem[bus.addr]};
    end

    assign bus.rdata = rdata_q;
endmodule

module top #(
    parameter int GLB_BYTES = 65536,
    parameter int FILT_ROW  = 3,
    parameter int FILT_COL  = 3,
    parameter int IFMAP_COL = 8,
    parameter int STRIDE    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] p,
    input  logic [3:0] t,
    input  logic [3:0] q,
    input  logic [3:0] r,
    input  logic [7:0] e,
    input  logic       start,
    output logic       done
);
    localparam int AW        = $clog2(GLB_BYTES);
    localparam int OFMAP_COL = (IFMAP_COL - FILT_COL) / STRIDE + 1;

    localparam logic [AW-1:0] SR = AW'(STRIDE);
    localparam logic [AW-1:0] RR = AW'(FILT_ROW);
    localparam logic [AW-1:0] SS = AW'(FILT_COL);
    localparam logic [AW-1:0] WW = AW'(IFMAP_COL);
    localparam logic [AW-1:0] FF = AW'(OFMAP_COL);

    localparam logic [7:0] R_LAST = 8'(FILT_ROW - 1);
    localparam logic [7:0] S_LAST = 8'(FILT_COL - 1);
    localparam logic [7:0] F_LAST = 8'(OFMAP_COL - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_BIAS,
        RD_IF,
        RD_FI,
        MAC,
        WR,
        DONE
    } state_e;

    state_e      state_q;
    logic [7:0]  m_tot_q;
    logic [7:0]  c_tot_q;
    logic [7:0]  e_q;
    logic [7:0]  m_q;
    logic [7:0]  y_q;
    logic [7:0]  x_q;
    logic [7:0]  c_q;
    logic [7:0]  rr_q;
    logic [7:0]  s_q;
    logic [31:0] acc_q;
    logic [7:0]  if_q;
    logic        done_q;

    top_if #(.AW(AW)) gbus ();

    top_glb #(
        .BYTES (GLB_BYTES),
        .AW    (AW)
    ) glb (
        .clk (clk),
        .bus (gbus)
    );

    logic [7:0] m_tot_d;
    logic [7:0] c_tot_d;
    logic       empty_d;

    assign m_tot_d = {4'd0, p} * {4'd0, t};
    assign c_tot_d = {4'd0, q} * {4'd0, r};
    assign empty_d = (m_tot_d == 8'd0) || (c_tot_d == 8'd0) || (e == 8'd0);

    logic [AW-1:0] m_w;
    logic [AW-1:0] y_w;
    logic [AW-1:0] x_w;
    logic [AW-1:0] c_w;
    logic [AW-1:0] rr_w;
    logic [AW-1:0] s_w;
    logic [AW-1:0] mt_w;
    logic [AW-1:0] ct_w;
    logic [AW-1:0] e_w;

    assign m_w  = AW'(m_q);
    assign y_w  = AW'(y_q);
    assign x_w  = AW'(x_q);
    assign c_w  = AW'(c_q);
    assign rr_w = AW'(rr_q);
    assign s_w  = AW'(s_q);
    assign mt_w = AW'(m_tot_q);
    assign ct_w = AW'(c_tot_q);
    assign e_w  = AW'(e_q);

    logic [AW-1:0] h_dim;
    logic [AW-1:0] fi_base;
    logic [AW-1:0] bi_base;
    logic [AW-1:0] op_base;
    logic [AW-1:0] if_addr;
    logic [AW-1:0] fi_addr;
    logic [AW-1:0] bi_addr;
    logic [AW-1:0] op_addr;

    // Layout arithmetic is done modulo the buffer size, like the GLB itself.
    assign h_dim   = SR * (e_w - AW'(1)) + RR;
    assign fi_base = ct_w * h_dim * WW;
    assign bi_base = fi_base + mt_w * ct_w * RR * SS;
    assign op_base = bi_base + AW'(4) * mt_w;

    assign if_addr = (c_w * h_dim + y_w * SR + rr_w) * WW + x_w * SR + s_w;
    assign fi_addr = fi_base + ((m_w * ct_w + c_w) * RR + rr_w) * SS + s_w;
    assign bi_addr = bi_base + AW'(4) * m_w;
    assign op_addr = op_base + AW'(4) * ((m_w * e_w + y_w) * FF + x_w);

    logic [31:0] wr_data;

`ifdef OPSUM_RELU_EN
    assign wr_data = acc_q[31] ? 32'd0 : acc_q;
`else
    assign wr_data = acc_q;
`endif

    always_comb begin
        gbus.addr  = '0;
        gbus.we    = 1'b0;
        gbus.wdata = wr_data;
        unique case (state_q)
            RD_BIAS: gbus.addr = bi_addr;
            RD_IF:   gbus.addr = if_addr;
            RD_FI:   gbus.addr = fi_addr;
            WR: begin
                gbus.addr = op_addr;
                gbus.we   = 1'b1;
            end
            default: gbus.addr = '0;
        endcase
    end

    logic signed [15:0] prod;
    logic               s_last;
    logic               rr_last;
    logic               c_last;
    logic               x_last;
    logic               y_last;
    logic               m_last;
    logic               inner_first;

    assign prod = 16'($signed(if_q)) * 16'($signed(gbus.rdata[7:0]));

    assign s_last  = (s_q == S_LAST);
    assign rr_last = (rr_q == R_LAST);
    assign c_last  = (c_q == c_tot_q - 8'd1);
    assign x_last  = (x_q == F_LAST);
    assign y_last  = (y_q == e_q - 8'd1);
    assign m_last  = (m_q == m_tot_q - 8'd1);

    // Only the read right after RD_BIAS sees all inner counters at zero.
    assign inner_first = (c_q == 8'd0) && (rr_q == 8'd0) && (s_q == 8'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            m_tot_q <= '0;
            c_tot_q <= '0;
            e_q     <= '0;
            m_q     <= '0;
            y_q     <= '0;
            x_q     <= '0;
            c_q     <= '0;
            rr_q    <= '0;
            s_q     <= '0;
            acc_q   <= '0;
            if_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        m_tot_q <= m_tot_d;
                        c_tot_q <= c_tot_d;
                        e_q     <= e;
                        done_q  <= 1'b0;
                        m_q     <= '0;
                        y_q     <= '0;
                        x_q     <= '0;
                        c_q     <= '0;
                        rr_q    <= '0;
                        s_q     <= '0;
                        state_q <= empty_d ? DONE : RD_BIAS;
                    end
                end
                RD_BIAS: state_q <= RD_IF;
                RD_IF: begin
                    if (inner_first) acc_q <= gbus.rdata;
                    state_q <= RD_FI;
                end
                RD_FI: begin
                    if_q    <= gbus.rdata[7:0];
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q   <= acc_q + 32'(prod);
                    state_q <= RD_IF;
                    if (!s_last) begin
                        s_q <= s_q + 8'd1;
                    end else begin
                        s_q <= '0;
                        if (!rr_last) begin
                            rr_q <= rr_q + 8'd1;
                        end else begin
                            rr_q <= '0;
                            if (!c_last) begin
                                c_q <= c_q + 8'd1;
                            end else begin
                                c_q     <= '0;
                                state_q <= WR;
                            end
                        end
                    end
                end
                WR: begin
                    state_q <= RD_BIAS;
                    if (!x_last) begin
                        x_q <= x_q + 8'd1;
                    end else begin
                        x_q <= '0;
                        if (!y_last) begin
                            y_q <= y_q + 8'd1;
                        end else begin
                            y_q <= '0;
                            if (!m_last) begin
                                m_q <= m_q + 8'd1;
                            end else begin
                                m_q     <= '0;
                                state_q <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done = done_q;
endmodule

// File: tb/tb_top.sv
// Directed bench for the convolution engine; GLB is preloaded and read back
// through hierarchy, expected opsums are hand-computed constants.
module tb_top;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] p = '0;
    logic [3:0] t = '0;
    logic [3:0] q = '0;
    logic [3:0] r = '0;
    logic [7:0] e = '0;
    logic       start = 1'b0;
    logic       done;

    int checks = 0;
    int failures = 0;

    top dut (
        .clk   (clk),
        .rst   (rst),
        .p     (p),
        .t     (t),
        .q     (q),
        .r     (r),
        .e     (e),
        .start (start),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base, input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) dut.glb.mem[base + i] = v;
    endtask

    task automatic set_word(input int a, input logic [31:0] v);
        for (int i = 0; i < 4; i++) dut.glb.mem[a + i] = v[8*i +: 8];
    endtask

    function automatic logic [31:0] rd_word(input int a);
        return {dut.glb.mem[a + 3], dut.glb.mem[a + 2],
                dut.glb.mem[a + 1], dut.glb.mem[a]};
    endfunction

    task automatic pulse_start(input logic [3:0] pp, input logic [3:0] tt,
                               input logic [3:0] qq, input logic [3:0] rr_,
                               input logic [7:0] ee);
        p = pp; t = tt; q = qq; r = rr_; e = ee;
        start = 1'b1;
        step(1);
        start = 1'b0;
        p = 4'hf; t = 4'hf; q = 4'hf; r = 4'hf; e = 8'hff;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            step(1);
            cyc++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        bit stayed_low = 1'b1;
        for (int i = 0; i < 64; i++) dut.glb.mem[i] = 8'(i) ^ 8'h5a;
        rst = 1'b0;
        step(2);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b want=0", done);
        end
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (done !== 1'b0) stayed_low = 1'b0;
        end
        checks++;
        if (!stayed_low) begin
            failures++;
            $display("FAIL idle_done_low got=rose want=stays0");
        end
        for (int i = 0; i < 64; i++) begin
            got = dut.glb.mem[i];
            checks++;
            if (got !== (8'(i) ^ 8'h5a)) begin
                failures++;
                $display("FAIL idle_glb[%0d] got=%h want=%h",
                         i, got, 8'(i) ^ 8'h5a);
            end
        end
    endtask

    task automatic test_ones();
        bit ok;
        int cyc;
        logic [31:0] got;
        fill(0, 400, 8'h00);
        fill(0, 24, 8'h01);
        fill(24, 9, 8'h01);
        set_word(33, 32'd0);
        fill(37, 28, 8'haa);
        pulse_start(4'd1, 4'd1, 4'd1, 4'd1, 8'd1);
        wait_done(2000, ok, cyc);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ones_done got=timeout want=done");
        end
        checks++;
        if (cyc > 6 * (4 * 9 + 8) + 4) begin
            failures++;
            $display("FAIL ones_cycles got=%0d want<=%0d", cyc, 6 * 44 + 4);
        end
        for (int i = 0; i < 6; i++) begin
            got = rd_word(37 + 4 * i);
            checks++;
            if (got !== 32'h0000_0009) begin
                failures++;
                $display("FAIL ones_op[%0d] got=%h want=00000009", i, got);
            end
        end
        got = rd_word(61);
        checks++;
        if (got !== 32'haaaa_aaaa) begin
            failures++;
            $display("FAIL ones_past_end got=%h want=aaaaaaaa", got);
        end
        step(10);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL ones_done_held got=%b want=1", done);
        end
    endtask

    task automatic test_signed();
        bit ok;
        int cyc;
        logic [31:0] got;
        logic [31:0] want;
`ifdef OPSUM_RELU_EN
        want = 32'h0000_0000;
`else
        want = 32'hffff_fff3;
`endif
        fill(0, 400, 8'h00);
        fill(0, 24, 8'hff);
        fill(24, 9, 8'h02);
        set_word(33, 32'd5);
        fill(37, 28, 8'haa);
        pulse_start(4'd1, 4'd1, 4'd1, 4'd1, 8'd1);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL signed_done_clr got=%b want=0", done);
        end
        wait_done(2000, ok, cyc);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL signed_done got=timeout want=done");
        end
        for (int i = 0; i < 6; i++) begin
            got = rd_word(37 + 4 * i);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL signed_op[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_multi();
        bit ok;
        int cyc;
        logic [31:0] got;
        logic [31:0] want;
        fill(0, 400, 8'h00);
        fill(0, 64, 8'h01);
        fill(64, 18, 8'h01);
        fill(82, 18, 8'h03);
        set_word(100, 32'd0);
        set_word(104, 32'd0);
        fill(108, 100, 8'haa);
        pulse_start(4'd1, 4'd2, 4'd2, 4'd1, 8'd2);
        wait_done(5000, ok, cyc);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL multi_done got=timeout want=done");
        end
        for (int i = 0; i < 24; i++) begin
            got = rd_word(108 + 4 * i);
            want = (i < 12) ? 32'h12 : 32'h36;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL multi_op[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_start_ignored();
        bit ok;
        int cyc;
        logic [31:0] got;
        logic [31:0] want;
        fill(108, 100, 8'haa);
        pulse_start(4'd1, 4'd2, 4'd2, 4'd1, 8'd2);
        step(100);
        pulse_start(4'd3, 4'd1, 4'd3, 4'd1, 8'd5);
        wait_done(5000, ok, cyc);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL ign_done got=timeout want=done");
        end
        for (int i = 0; i < 24; i++) begin
            got = rd_word(108 + 4 * i);
            want = (i < 12) ? 32'h12 : 32'h36;
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL ign_op[%0d] got=%h want=%h", i, got, want);
            end
        end
        got = rd_word(108 + 96);
        checks++;
        if (got !== 32'haaaa_aaaa) begin
            failures++;
            $display("FAIL ign_past_end got=%h want=aaaaaaaa", got);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        logic [31:0] got;
        fill(0, 400, 8'h00);
        fill(0, 24, 8'h01);
        fill(24, 9, 8'h01);
        set_word(33, 32'd0);
        fill(37, 28, 8'haa);
        pulse_start(4'd1, 4'd1, 4'd1, 4'd1, 8'd1);
        step(60);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL rmid_done got=%b want=0", done);
        end
        checks++;
        if (dut.state_q != 0) begin
            failures++;
            $display("FAIL rmid_state got=%0d want=0", dut.state_q);
        end
        got = rd_word(37);
        checks++;
        if (got !== 32'h0000_0009) begin
            failures++;
            $display("FAIL rmid_partial got=%h want=00000009", got);
        end
        step(20);
        checks++;
        if (done !== 1'b0 || rd_word(57) !== 32'haaaa_aaaa) begin
            failures++;
            $display("FAIL rmid_aborted got=done%b/%h want=done0/aaaaaaaa",
                     done, rd_word(57));
        end
        pulse_start(4'd1, 4'd1, 4'd1, 4'd1, 8'd1);
        wait_done(2000, ok, cyc);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rmid_redo_done got=timeout want=done");
        end
        for (int i = 0; i < 6; i++) begin
            got = rd_word(37 + 4 * i);
            checks++;
            if (got !== 32'h0000_0009) begin
                failures++;
                $display("FAIL rmid_op[%0d] got=%h want=00000009", i, got);
            end
        end
    endtask

    task automatic test_zero_dims();
        bit ok;
        int cyc;
        logic [31:0] got;
        fill(0, 400, 8'h00);
        fill(24, 40, 8'haa);
        pulse_start(4'd0, 4'd1, 4'd1, 4'd1, 8'd1);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_clr got=%b want=0", done);
        end
        wait_done(4, ok, cyc);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL zero_m_done got=late want=within4");
        end
        for (int i = 0; i < 10; i++) begin
            got = rd_word(24 + 4 * i);
            checks++;
            if (got !== 32'haaaa_aaaa) begin
                failures++;
                $display("FAIL zero_glb[%0d] got=%h want=aaaaaaaa", i, got);
            end
        end
        pulse_start(4'd1, 4'd1, 4'd1, 4'd1, 8'd0);
        wait_done(4, ok, cyc);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL zero_e_done got=late want=within4");
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_signed();
        test_multi();
        test_start_ignored();
        test_reset_mid();
        test_zero_dims();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
